// File: rtl/gelato_operand_collector_pkg.sv
// Shared types for the operand collector: instruction, collector entry,
// register-file request tag and the warp-wide operand word.
package gelato_operand_collector_pkg;
   localparam int COLLECTOR_NUM = 4;
   localparam int THREAD_NUM    = 4;
   localparam int DATA_WIDTH    = 8;
   localparam int WARP_W        = 3;
   localparam int REG_W         = 5;
   localparam int CIDX_W        = $clog2(COLLECTOR_NUM);

   typedef logic [WARP_W-1:0] warp_num_t;
   typedef logic [REG_W-1:0]  reg_num_t;
   typedef logic [1:0]        rs_num_t;
   typedef logic [CIDX_W-1:0] collector_num_t;
   typedef logic [THREAD_NUM-1:0][DATA_WIDTH-1:0] warp_reg_t;

   typedef struct packed {
      warp_num_t  warp;
      logic [7:0] opcode;
      reg_num_t   rd;
      reg_num_t   rs1;
      reg_num_t   rs2;
      reg_num_t   rs3;
   } inst_t;

   typedef struct packed {
      logic      valid;
      inst_t     inst;
      reg_num_t  rs1;
      reg_num_t  rs2;
      reg_num_t  rs3;
      warp_reg_t rs_data1;
      warp_reg_t rs_data2;
      warp_reg_t rs_data3;
      logic      rs_valid1;
      logic      rs_valid2;
      logic      rs_valid3;
   } collector_entry_t;

   // Slot numbering is 1..3 for rs1..rs3; 0 never appears on a live tag.
   typedef struct packed {
      collector_num_t entry;
      rs_num_t        slot;
   } rf_tag_t;

   function automatic reg_num_t inst_rs(inst_t i, int k);
      case (k)
         0:       return i.rs1;
         1:       return i.rs2;
         default: return i.rs3;
      endcase
   endfunction
endpackage

// File: rtl/gelato_operand_collector_if.sv
// Issue, register-file request/response and dispatch signals of the collector.
interface gelato_operand_collector_if;
   import gelato_operand_collector_pkg::*;

   logic             inst_valid;
   logic             inst_ready;
   inst_t            inst;
   logic             rf_req_valid;
   logic             rf_req_ready;
   warp_num_t        rf_req_warp;
   reg_num_t         rf_req_reg;
   rf_tag_t          rf_req_tag;
   logic             rf_rsp_valid;
   rf_tag_t          rf_rsp_tag;
   warp_reg_t        rf_rsp_data;
   logic             disp_valid;
   logic             disp_ready;
   collector_entry_t disp_entry;

   modport slave (
      input  inst_valid, inst, rf_req_ready, rf_rsp_valid, rf_rsp_tag, rf_rsp_data, disp_ready,
      output inst_ready, rf_req_valid, rf_req_warp, rf_req_reg, rf_req_tag, disp_valid, disp_entry
   );

   modport master (
      output inst_valid, inst, rf_req_ready, rf_rsp_valid, rf_rsp_tag, rf_rsp_data, disp_ready,
      input  inst_ready, rf_req_valid, rf_req_warp, rf_req_reg, rf_req_tag, disp_valid, disp_entry
   );
endinterface

// File: rtl/gelato_operand_collector_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr_i (wrapping) wins.
module gelato_rr_arbiter #(
   parameter int N = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!any_o && req_i[ptr_i + IW'(i)]) begin
            any_o = 1'b1;
            idx_o = ptr_i + IW'(i);
         end
      end
      grant_o[idx_o] = any_o;
   end
endmodule

// File: rtl/gelato_operand_collector.sv
// Operand collector: buffers issued instructions, fetches rs1..rs3 through one
// tagged register-file port and dispatches complete entries round-robin.
module gelato_operand_collector
   import gelato_operand_collector_pkg::*;
(
   input logic clk,
   input logic rst_n,
   gelato_operand_collector_if.slave bus
);
   localparam int N = COLLECTOR_NUM;

   logic [N-1:0]      valid_q, valid_d;
   logic [N-1:0][2:0] pend_q, pend_d, rsv_q, rsv_d;
   inst_t             inst_q [N];
   warp_reg_t         data_q [N][3];
   collector_num_t    req_ptr_q, req_ptr_d, disp_ptr_q, disp_ptr_d;
   logic              req_lock_q, req_lock_d, disp_lock_q, disp_lock_d;
   collector_num_t    req_lock_idx_q, req_lock_idx_d, disp_lock_idx_q, disp_lock_idx_d;

   logic              alloc_any;
   collector_num_t    alloc_idx;
   logic [N-1:0]      req_elig, disp_elig, req_arb_in, disp_arb_in;
   logic [N-1:0]      req_gnt, disp_gnt;
   collector_num_t    req_idx, disp_idx;
   logic              req_any, disp_any;
   logic [2:0]        wait_mask;
   rs_num_t           req_slot, req_k, rsp_k;
   reg_num_t          req_reg;
   logic              alloc_hs, req_hs, disp_hs, rsp_ok;

   always_comb begin
      alloc_any = 1'b0;
      alloc_idx = '0;
      for (int e = N-1; e >= 0; e--) begin
         if (!valid_q[e]) begin
            alloc_any = 1'b1;
            alloc_idx = collector_num_t'(e);
         end
      end
   end

   always_comb begin
      req_elig  = '0;
      disp_elig = '0;
      for (int e = 0; e < N; e++) begin
         req_elig[e]  = valid_q[e] && ((~rsv_q[e] & ~pend_q[e]) != 3'b000);
         disp_elig[e] = valid_q[e] && (&rsv_q[e]);
      end
   end

   // An offer not yet accepted pins the arbiter to that entry so the bus holds steady.
   assign req_arb_in  = req_lock_q  ? ({{(N-1){1'b0}}, 1'b1} << req_lock_idx_q)  : req_elig;
   assign disp_arb_in = disp_lock_q ? ({{(N-1){1'b0}}, 1'b1} << disp_lock_idx_q) : disp_elig;

   gelato_rr_arbiter #(.N(N)) u_req_arb (
      .req_i(req_arb_in), .ptr_i(req_ptr_q), .grant_o(req_gnt), .idx_o(req_idx), .any_o(req_any)
   );

   gelato_rr_arbiter #(.N(N)) u_disp_arb (
      .req_i(disp_arb_in), .ptr_i(disp_ptr_q), .grant_o(disp_gnt), .idx_o(disp_idx), .any_o(disp_any)
   );

   always_comb begin
      wait_mask = req_any ? (~rsv_q[req_idx] & ~pend_q[req_idx]) : 3'b000;
      req_slot  = '0;
      req_reg   = '0;
      for (int k = 2; k >= 0; k--) begin
         if (wait_mask[k]) begin
            req_slot = rs_num_t'(k + 1);
            req_reg  = inst_rs(inst_q[req_idx], k);
         end
      end
   end

   assign req_k           = req_slot - 2'd1;
   assign rsp_k           = bus.rf_rsp_tag.slot - 2'd1;
   assign bus.inst_ready  = alloc_any;
   assign bus.rf_req_valid = req_any;
   assign bus.rf_req_warp = req_any ? inst_q[req_idx].warp : '0;
   assign bus.rf_req_reg  = req_reg;
   assign bus.rf_req_tag  = req_any ? {req_idx, req_slot} : '0;
   assign bus.disp_valid  = disp_any;

   always_comb begin
      bus.disp_entry = '0;
      if (disp_any) begin
         bus.disp_entry.valid     = 1'b1;
         bus.disp_entry.inst      = inst_q[disp_idx];
         bus.disp_entry.rs1       = inst_q[disp_idx].rs1;
         bus.disp_entry.rs2       = inst_q[disp_idx].rs2;
         bus.disp_entry.rs3       = inst_q[disp_idx].rs3;
         bus.disp_entry.rs_data1  = data_q[disp_idx][0];
         bus.disp_entry.rs_data2  = data_q[disp_idx][1];
         bus.disp_entry.rs_data3  = data_q[disp_idx][2];
         bus.disp_entry.rs_valid1 = rsv_q[disp_idx][0];
         bus.disp_entry.rs_valid2 = rsv_q[disp_idx][1];
         bus.disp_entry.rs_valid3 = rsv_q[disp_idx][2];
      end
   end

   assign alloc_hs = bus.inst_valid && alloc_any;
   assign req_hs   = req_any && bus.rf_req_ready;
   assign disp_hs  = disp_any && bus.disp_ready;
   // Responses to slots that are not pending (stale or bogus tags) are dropped.
   assign rsp_ok   = bus.rf_rsp_valid && (bus.rf_rsp_tag.slot != 2'd0) &&
                     valid_q[bus.rf_rsp_tag.entry] && pend_q[bus.rf_rsp_tag.entry][rsp_k];

   always_comb begin
      valid_d         = valid_q;
      pend_d          = pend_q;
      rsv_d           = rsv_q;
      req_ptr_d       = req_hs ? req_idx + 1'b1 : req_ptr_q;
      disp_ptr_d      = disp_hs ? disp_idx + 1'b1 : disp_ptr_q;
      req_lock_d      = req_any && !bus.rf_req_ready;
      req_lock_idx_d  = req_idx;
      disp_lock_d     = disp_any && !bus.disp_ready;
      disp_lock_idx_d = disp_idx;
      for (int e = 0; e < N; e++) begin
         if (alloc_hs && alloc_idx == collector_num_t'(e)) begin
            valid_d[e] = 1'b1;
            pend_d[e]  = 3'b000;
            rsv_d[e]   = {bus.inst.rs3 == '0, bus.inst.rs2 == '0, bus.inst.rs1 == '0};
         end
         if (disp_hs && disp_gnt[e]) valid_d[e] = 1'b0;
         if (req_hs && req_gnt[e]) pend_d[e][req_k] = 1'b1;
         if (rsp_ok && bus.rf_rsp_tag.entry == collector_num_t'(e)) begin
            pend_d[e][rsp_k] = 1'b0;
            rsv_d[e][rsp_k]  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q         <= '0;
         pend_q          <= '0;
         rsv_q           <= '0;
         req_ptr_q       <= '0;
         disp_ptr_q      <= '0;
         req_lock_q      <= 1'b0;
         disp_lock_q     <= 1'b0;
         req_lock_idx_q  <= '0;
         disp_lock_idx_q <= '0;
      end else begin
         valid_q         <= valid_d;
         pend_q          <= pend_d;
         rsv_q           <= rsv_d;
         req_ptr_q       <= req_ptr_d;
         disp_ptr_q      <= disp_ptr_d;
         req_lock_q      <= req_lock_d;
         disp_lock_q     <= disp_lock_d;
         req_lock_idx_q  <= req_lock_idx_d;
         disp_lock_idx_q <= disp_lock_idx_d;
      end
   end

   // Operand storage is qualified by the control bits above and needs no reset.
   always_ff @(posedge clk) begin
      if (alloc_hs) begin
         inst_q[alloc_idx] <= bus.inst;
         for (int k = 0; k < 3; k++) data_q[alloc_idx][k] <= '0;
      end
      if (rsp_ok) data_q[bus.rf_rsp_tag.entry][rsp_k] <= bus.rf_rsp_data;
   end
endmodule

// File: tb/tb_gelato_operand_collector.sv
// Randomized bench for gelato_operand_collector against an entry-level model.
module tb_gelato_operand_collector;
   import gelato_operand_collector_pkg::*;

   localparam int N = COLLECTOR_NUM;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   gelato_operand_collector_if ifc();
   gelato_operand_collector dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   task automatic check_val(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   typedef struct {
      bit       occ;
      inst_t    inst;
      bit [2:0] need;
      bit [2:0] reqd;
      bit [2:0] got;
   } ment_t;

   typedef struct {
      rf_tag_t   tag;
      warp_reg_t data;
      int        due;
   } rsp_t;

   ment_t m [N];
   rsp_t  rq [$];
   int    m_req_ptr, m_disp_ptr, m_req_lock_e, m_disp_lock_e;
   bit    m_req_lock, m_disp_lock, last_alloc;

   bit    k_inst_v, k_req_rdy, k_disp_rdy, k_rsp_en, k_rsp_newest;
   inst_t k_inst;
   int    k_lat_min, k_lat_max;
   logic [7:0] next_id = 8'd1;

   function automatic warp_reg_t rf_val(warp_num_t w, reg_num_t r);
      warp_reg_t v;
      for (int t = 0; t < THREAD_NUM; t++) v[t] = {w, r} ^ 8'(t * 37 + 1);
      return v;
   endfunction

   function automatic int rr_pick(bit [N-1:0] v, int ptr);
      for (int i = 0; i < N; i++) if (v[(ptr + i) % N]) return (ptr + i) % N;
      return -1;
   endfunction

   function automatic warp_reg_t exp_data(int e, int k);
      return m[e].need[k] ? rf_val(m[e].inst.warp, inst_rs(m[e].inst, k)) : '0;
   endfunction

   function automatic inst_t mk(reg_num_t a, reg_num_t b, reg_num_t c);
      inst_t i;
      i.warp = warp_num_t'($urandom);
      i.opcode = next_id;
      i.rd = reg_num_t'($urandom);
      i.rs1 = a; i.rs2 = b; i.rs3 = c;
      next_id++;
      return i;
   endfunction

   function automatic reg_num_t rand_rs();
      return ($urandom_range(2) == 0) ? reg_num_t'(0) : reg_num_t'($urandom_range(31, 1));
   endfunction

   function automatic int occupancy();
      int n = 0;
      for (int e = 0; e < N; e++) if (m[e].occ) n++;
      return n;
   endfunction

   task automatic drive_idle();
      ifc.inst_valid = 1'b0; ifc.inst = '0; ifc.rf_req_ready = 1'b0; ifc.disp_ready = 1'b0;
      ifc.rf_rsp_valid = 1'b0; ifc.rf_rsp_tag = '0; ifc.rf_rsp_data = '0;
   endtask

   // One clock: check outputs against the model, drive inputs, advance the model.
   task automatic step();
      bit [N-1:0] rv, dv;
      int fe, re, rk, de, pick, e, kk;
      @(negedge clk);
      rv = '0; dv = '0; fe = -1; rk = -1;
      for (int i = 0; i < N; i++) begin
         rv[i] = m[i].occ && ((m[i].need & ~m[i].reqd) != 3'b000);
         dv[i] = m[i].occ && ((m[i].need & ~m[i].got) == 3'b000);
      end
      for (int i = N-1; i >= 0; i--) if (!m[i].occ) fe = i;
      re = m_req_lock ? m_req_lock_e : rr_pick(rv, m_req_ptr);
      de = m_disp_lock ? m_disp_lock_e : rr_pick(dv, m_disp_ptr);

      check_val("inst_ready", ifc.inst_ready, fe >= 0);
      check_val("rf_req_valid", ifc.rf_req_valid, re >= 0);
      check_val("disp_valid", ifc.disp_valid, de >= 0);
      if (re >= 0) begin
         for (int k = 2; k >= 0; k--) if (m[re].need[k] && !m[re].reqd[k]) rk = k;
         check_val("req_tag", ifc.rf_req_tag, {collector_num_t'(re), rs_num_t'(rk + 1)});
         check_val("req_warp", ifc.rf_req_warp, m[re].inst.warp);
         check_val("req_reg", ifc.rf_req_reg, inst_rs(m[re].inst, rk));
      end
      if (de >= 0) begin
         check_val("disp_inst", ifc.disp_entry.inst, m[de].inst);
         check_val("disp_flags", {ifc.disp_entry.valid, ifc.disp_entry.rs_valid1,
                   ifc.disp_entry.rs_valid2, ifc.disp_entry.rs_valid3}, 4'hF);
         check_val("disp_rs", {ifc.disp_entry.rs1, ifc.disp_entry.rs2, ifc.disp_entry.rs3},
                   {m[de].inst.rs1, m[de].inst.rs2, m[de].inst.rs3});
         check_val("disp_data1", ifc.disp_entry.rs_data1, exp_data(de, 0));
         check_val("disp_data2", ifc.disp_entry.rs_data2, exp_data(de, 1));
         check_val("disp_data3", ifc.disp_entry.rs_data3, exp_data(de, 2));
      end else begin
         check_val("disp_entry_zero", ifc.disp_entry == '0, 1'b1);
      end

      ifc.inst_valid = k_inst_v; ifc.inst = k_inst;
      ifc.rf_req_ready = k_req_rdy; ifc.disp_ready = k_disp_rdy;
      ifc.rf_rsp_valid = 1'b0; ifc.rf_rsp_tag = '0; ifc.rf_rsp_data = '0;
      pick = -1;
      if (k_rsp_en)
         for (int i = 0; i < rq.size(); i++)
            if (rq[i].due <= cyc && (pick < 0 || k_rsp_newest || $urandom_range(1) == 1)) pick = i;
      if (pick >= 0) begin
         ifc.rf_rsp_valid = 1'b1; ifc.rf_rsp_tag = rq[pick].tag; ifc.rf_rsp_data = rq[pick].data;
         e = int'(rq[pick].tag.entry); kk = int'(rq[pick].tag.slot) - 1;
         if (kk >= 0 && m[e].occ && m[e].reqd[kk] && !m[e].got[kk]) m[e].got[kk] = 1'b1;
         rq.delete(pick);
      end

      if (re >= 0) begin
         if (k_req_rdy) begin
            m[re].reqd[rk] = 1'b1;
            rq.push_back('{tag: {collector_num_t'(re), rs_num_t'(rk + 1)},
                           data: rf_val(m[re].inst.warp, inst_rs(m[re].inst, rk)),
                           due: cyc + $urandom_range(k_lat_max, k_lat_min)});
            m_req_ptr = (re + 1) % N; m_req_lock = 1'b0;
         end else begin
            m_req_lock = 1'b1; m_req_lock_e = re;
         end
      end
      if (de >= 0) begin
         if (k_disp_rdy) begin
            m[de].occ = 1'b0; m_disp_ptr = (de + 1) % N; m_disp_lock = 1'b0;
         end else begin
            m_disp_lock = 1'b1; m_disp_lock_e = de;
         end
      end
      last_alloc = k_inst_v && fe >= 0;
      if (last_alloc) begin
         m[fe].occ = 1'b1; m[fe].inst = k_inst;
         m[fe].need = {k_inst.rs3 != 0, k_inst.rs2 != 0, k_inst.rs1 != 0};
         m[fe].reqd = '0; m[fe].got = '0;
      end
      cyc++;
   endtask

   task automatic steps(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic push(inst_t i);
      int budget = 60;
      k_inst_v = 1'b1; k_inst = i;
      do begin step(); budget--; end while (!last_alloc && budget > 0);
      check_val("push_accepted", last_alloc, 1'b1);
      k_inst_v = 1'b0;
   endtask

   task automatic do_reset(int hold);
      @(negedge clk);
      rst_n = 1'b0;
      drive_idle();
      #1;
      check_val("rst_inst_ready", ifc.inst_ready, 1'b1);
      check_val("rst_req_valid", ifc.rf_req_valid, 1'b0);
      check_val("rst_disp_valid", ifc.disp_valid, 1'b0);
      check_val("rst_disp_entry", ifc.disp_entry == '0, 1'b1);
      for (int e = 0; e < N; e++) begin m[e].occ = 1'b0; m[e].reqd = '0; m[e].got = '0; m[e].need = '0; end
      m_req_ptr = 0; m_disp_ptr = 0; m_req_lock = 1'b0; m_disp_lock = 1'b0;
      repeat (hold) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drain();
      int budget = 300;
      k_inst_v = 1'b0; k_req_rdy = 1'b1; k_disp_rdy = 1'b1; k_rsp_en = 1'b1; k_rsp_newest = 1'b0;
      while ((occupancy() != 0 || m_disp_lock) && budget > 0) begin step(); budget--; end
      check_val("drain_empty", occupancy(), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      drive_idle();
      k_inst_v = 1'b0; k_inst = '0; k_req_rdy = 1'b1; k_disp_rdy = 1'b1;
      k_rsp_en = 1'b1; k_rsp_newest = 1'b0; k_lat_min = 2; k_lat_max = 2;
      do_reset(2);

      // Zero-operand instruction: offered the cycle after allocation.
      push(mk(0, 0, 0));
      steps(3);

      // Two register operands with fixed latency 2.
      push(mk(5, 6, 0));
      steps(8);

      // Fill all entries with dispatch stalled, then free one.
      k_disp_rdy = 1'b0; k_lat_min = 1; k_lat_max = 3;
      for (int i = 0; i < N; i++) push(mk(rand_rs(), reg_num_t'($urandom_range(31, 1)), rand_rs()));
      steps(16);
      k_inst_v = 1'b1; k_inst = mk(9, 10, 0);
      steps(2);
      k_disp_rdy = 1'b1; step();
      k_disp_rdy = 1'b0;
      push(k_inst);
      steps(6);
      drain();

      // Request stall and reversed response order.
      k_req_rdy = 1'b0; k_rsp_en = 1'b0;
      k_inst_v = 1'b1; k_inst = mk(7, 8, 9); step(); k_inst_v = 1'b0;
      steps(10);
      k_req_rdy = 1'b1;
      steps(6);
      k_rsp_en = 1'b1; k_rsp_newest = 1'b1;
      steps(6);
      drain();

      // Several entries complete while dispatch is held, then release.
      k_disp_rdy = 1'b0;
      push(mk(3, 0, 0)); push(mk(4, 0, 0)); push(mk(11, 0, 0));
      steps(8);
      k_disp_rdy = 1'b1;
      steps(4);
      push(mk(12, 0, 0)); push(mk(0, 0, 0));
      k_disp_rdy = 1'b0; steps(6); k_disp_rdy = 1'b1;
      drain();

      // Reset with requests outstanding; stale responses must be dropped.
      k_rsp_en = 1'b0;
      push(mk(13, 14, 0)); push(mk(15, 0, 16));
      steps(3);
      do_reset(2);
      k_rsp_en = 1'b1;
      for (int i = 0; i < 20 && rq.size() != 0; i++) step();
      check_val("stale_flushed", rq.size(), 0);
      push(mk(17, 18, 19));
      drain();

      // Randomized traffic.
      k_lat_min = 1; k_lat_max = 5;
      for (int c = 0; c < 800; c++) begin
         k_inst_v     = $urandom_range(1);
         k_inst       = mk(rand_rs(), rand_rs(), rand_rs());
         k_req_rdy    = $urandom_range(9) < 7;
         k_disp_rdy   = $urandom_range(9) < 6;
         k_rsp_en     = $urandom_range(9) < 8;
         k_rsp_newest = $urandom_range(3) == 0;
         step();
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
